// File: rtl/rv_pkg.sv
// Shared core definitions: default widths, reset PC, NOP encoding and the
// fetch-unit state encoding.
package rv_pkg;

    localparam int unsigned RV_ADDR_W   = 64;
    localparam int unsigned RV_INST_W   = 32;
    localparam logic [63:0] RV_RESET_PC = 64'h0;
    localparam logic [31:0] RV_NOP      = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } ifu_state_e;

endpackage

// File: rtl/ifu_inst_fifo.sv
// Instruction buffer: synchronous FIFO holding instruction words with their
// PCs, combinational head read, flush taking priority over push/pop.
module ifu_inst_fifo #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic [ADDR_W-1:0]        push_addr,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head_data,
    output logic [ADDR_W-1:0]        head_addr,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] data_mem [DEPTH];
    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                addr_mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Push into a full FIFO is only legal alongside a pop; the slot
            // written is the one being vacated this edge.
            if (push) begin
                data_mem[wr_ptr] <= push_data;
                addr_mem[wr_ptr] <= push_addr;
                wr_ptr           <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    assign head_data = data_mem[rd_ptr];
    assign head_addr = addr_mem[rd_ptr];
    assign empty     = (count == '0);

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch stage: sequential ROM fetch, credit-limited issue, buffered
// delivery to decode, redirect flush. Optional macro: IFU_MISALIGN_TRAP_EN.
module ifu_fetch
    import rv_pkg::*;
#(
    parameter int unsigned       ADDR_W     = RV_ADDR_W,
    parameter int unsigned       INST_W     = RV_INST_W,
    parameter logic [ADDR_W-1:0] RESET_PC   = ADDR_W'(RV_RESET_PC),
    parameter int unsigned       FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              jump_en_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    output logic              rom_req_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic [INST_W-1:0] rom_rdata_i,
    output logic              inst_valid_o,
    input  logic              inst_ready_i,
    output logic [INST_W-1:0] inst_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic              fetch_misalign_o
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    ifu_state_e        state;
    logic [ADDR_W-1:0] pc;
    logic              inflight;
    logic              inflight_epoch;
    logic [ADDR_W-1:0] inflight_addr;
    logic              epoch;

    logic [CNT_W-1:0]  fifo_count;
    logic [CNT_W-1:0]  credits_used;
    logic              fifo_empty;
    logic              pop;
    logic              push;
    logic              issue;
    logic [ADDR_W-1:0] jump_target;

    assign jump_target  = jump_addr_i & ~ADDR_W'(3);
    assign pop          = inst_valid_o & inst_ready_i;
    assign credits_used = fifo_count + CNT_W'(inflight) - CNT_W'(pop);
    assign issue        = (state == RUN) && !jump_en_i
                          && (credits_used < CNT_W'(FIFO_DEPTH));

    // A response belongs to the current stream only if no redirect landed
    // since its issue; anything arriving during the redirect cycle is flushed.
    assign push = inflight && (inflight_epoch == epoch);

    assign rom_req_o  = issue;
    assign rom_addr_o = pc;

`ifdef IFU_MISALIGN_TRAP_EN
    logic misalign_q;
    assign fetch_misalign_o = misalign_q;
`else
    assign fetch_misalign_o = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            pc             <= RESET_PC;
            inflight       <= 1'b0;
            inflight_epoch <= 1'b0;
            inflight_addr  <= '0;
            epoch          <= 1'b0;
`ifdef IFU_MISALIGN_TRAP_EN
            misalign_q     <= 1'b0;
`endif
        end else begin
            inflight <= issue;
            if (issue) begin
                inflight_addr  <= pc;
                inflight_epoch <= epoch;
                pc             <= pc + ADDR_W'(4);
            end
            if (jump_en_i) begin
                pc    <= jump_target;
                epoch <= ~epoch;
            end

            case (state)
                IDLE:    state <= RUN;
                default: state <= state;
            endcase

`ifdef IFU_MISALIGN_TRAP_EN
            if (jump_en_i) begin
                if (jump_addr_i[1:0] != 2'b00) begin
                    state      <= HALT;
                    misalign_q <= 1'b1;
                end else begin
                    state      <= RUN;
                    misalign_q <= 1'b0;
                end
            end
`endif
        end
    end

    ifu_inst_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .DATA_W (INST_W),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (jump_en_i),
        .push      (push),
        .push_data (rom_rdata_i),
        .push_addr (inflight_addr),
        .pop       (pop),
        .head_data (inst_o),
        .head_addr (inst_addr_o),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign inst_valid_o = !fifo_empty;

endmodule
